// File: rtl/gpio_irq_debouncer.sv
// Multi-channel GPIO/button interrupt front end: per-channel synchroniser, stability
// debouncer, edge/level event detection, pending/overflow latches and one combined IRQ.
module gpio_irq_debouncer #(
    parameter int CHANNELS             = 4,
    parameter int DEBOUNCER_FACTOR_POW = 2,
    parameter int SYNC_STAGES          = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [CHANNELS-1:0]   btn_i,
    input  logic [2*CHANNELS-1:0] mode_i,
    input  logic [CHANNELS-1:0]   en_i,
    input  logic [CHANNELS-1:0]   clr_i,
    output logic [CHANNELS-1:0]   db_o,
    output logic [CHANNELS-1:0]   pending_o,
    output logic [CHANNELS-1:0]   ovf_o,
    output logic                  irq_o
);

    localparam logic [1:0] MODE_LEVEL = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;

    typedef logic [DEBOUNCER_FACTOR_POW-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    cnt_t                   cnt_q  [CHANNELS];
    cnt_t                   cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]    sync_s;
    logic [CHANNELS-1:0]    db_q, db_d;
    logic [CHANNELS-1:0]    event_w;
    logic [CHANNELS-1:0]    pending_q, pending_d;
    logic [CHANNELS-1:0]    ovf_q, ovf_d;

    // Oldest synchroniser stage sits at the MSB.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int k = 0; k < CHANNELS; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], btn_i[k]};
            end
        end
    end

    always_comb begin
        sync_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sync_s[k] = sync_q[k][SYNC_STAGES-1];
        end
    end

    // Counter only advances while the synchronised input disagrees with db, so it never wraps.
    always_comb begin
        db_d = db_q;
        for (int k = 0; k < CHANNELS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (sync_s[k] == db_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                db_d[k]  = sync_s[k];
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + cnt_t'(1);
            end
        end
    end

    always_comb begin
        event_w = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            case (mode_i[2*k +: 2])
                MODE_LEVEL: event_w[k] = db_d[k];
                MODE_RISE:  event_w[k] = ~db_q[k] & db_d[k];
                MODE_FALL:  event_w[k] = db_q[k] & ~db_d[k];
                default:    event_w[k] = db_q[k] ^ db_d[k];
            endcase
        end
    end

    // Set wins over clear; level-mode events never flag overflow.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (event_w[k] && en_i[k]) begin
                pending_d[k] = 1'b1;
                if (pending_q[k] && !clr_i[k] && (mode_i[2*k +: 2] != MODE_LEVEL)) begin
                    ovf_d[k] = 1'b1;
                end
            end else if (clr_i[k]) begin
                pending_d[k] = 1'b0;
                ovf_d[k]     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= '0;
            end
            db_q      <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            db_q      <= db_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign db_o      = db_q;
    assign pending_o = pending_q;
    assign ovf_o     = ovf_q;
    assign irq_o     = |(pending_q & en_i);

endmodule

// File: tb/tb_gpio_irq_debouncer.sv
// Scoreboard bench for gpio_irq_debouncer: directed scenarios plus random traffic, checked
// against a sample-window model of debounce plus the event/pending rules.
module tb_gpio_irq_debouncer;

    localparam int CH = 4;
    localparam int POW = 2;
    localparam int SS = 2;
    localparam int N = 1 << POW;
    localparam int HL = SS + N;
    localparam int W = 3 * CH + 1;
    localparam logic [2*CH-1:0] MODES = {2'b01, 2'b00, 2'b11, 2'b01};

    logic            clk = 1'b0;
    logic            arst = 1'b1;
    logic [CH-1:0]   btn = '0;
    logic [2*CH-1:0] mode = MODES;
    logic [CH-1:0]   en = '0;
    logic [CH-1:0]   clr = '0;
    logic [CH-1:0]   db, pending, ovf;
    logic            irq;

    gpio_irq_debouncer #(
        .CHANNELS(CH),
        .DEBOUNCER_FACTOR_POW(POW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_i(clk),
        .arst_i(arst),
        .btn_i(btn),
        .mode_i(mode),
        .en_i(en),
        .clr_i(clr),
        .db_o(db),
        .pending_o(pending),
        .ovf_o(ovf),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int checks = 0;
    int errors = 0;

    // Model: hist[i] is the raw input sampled i edges ago; db flips once the N samples
    // visible through the synchroniser all disagree with it.
    logic [CH-1:0] hist [HL];
    logic [CH-1:0] m_db, m_pend, m_ovf;

    task automatic model_reset();
        for (int i = 0; i < HL; i++) hist[i] = '0;
        m_db = '0;
        m_pend = '0;
        m_ovf = '0;
    endtask

    task automatic model_edge();
        logic all_diff, nd, ev;
        logic [1:0] md;
        for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = btn;
        for (int k = 0; k < CH; k++) begin
            all_diff = 1'b1;
            for (int i = SS; i < HL; i++) if (hist[i][k] == m_db[k]) all_diff = 1'b0;
            nd = all_diff ? ~m_db[k] : m_db[k];
            md = mode[2*k +: 2];
            case (md)
                2'b00: ev = nd;
                2'b01: ev = nd && !m_db[k];
                2'b10: ev = !nd && m_db[k];
                default: ev = nd != m_db[k];
            endcase
            if (ev && en[k]) begin
                if (m_pend[k] && !clr[k] && md != 2'b00) m_ovf[k] = 1'b1;
                m_pend[k] = 1'b1;
            end else if (clr[k]) begin
                m_pend[k] = 1'b0;
                m_ovf[k] = 1'b0;
            end
            m_db[k] = nd;
        end
    endtask

    task automatic cycle(input logic [CH-1:0] b, input logic [2*CH-1:0] m,
                         input logic [CH-1:0] e, input logic [CH-1:0] c);
        btn = b;
        mode = m;
        en = e;
        clr = c;
        @(posedge clk);
        model_edge();
        #1;
        exp_q.push_back({m_db, m_pend, m_ovf, |(m_pend & en)});
        @(negedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic [CH-1:0] b, input logic [CH-1:0] e);
        repeat (n) cycle(b, MODES, e, '0);
    endtask

    // Pulses reset between clock edges so only an asynchronous clear can take effect.
    task automatic pulse_reset();
        arst = 1'b1;
        model_reset();
        #2;
        arst = 1'b0;
    endtask

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("db", db, mon_exp[3*CH:2*CH+1]);
                check("pending", pending, mon_exp[2*CH:CH+1]);
                check("ovf", ovf, mon_exp[CH:1]);
                check("irq", {{(CH-1){1'b0}}, irq}, {{(CH-1){1'b0}}, mon_exp[0]});
            end
        end
    end

    logic [CH-1:0]   cur_b, cur_e, cur_c;
    logic [2*CH-1:0] cur_m;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        arst = 1'b0;

        hold(4, 4'b0000, 4'b1111);
        // Reset in the middle of a debounce count.
        hold(3, 4'b0001, 4'b1111);
        pulse_reset();
        hold(8, 4'b0000, 4'b1111);

        // ch0 rising edge, clear, then a fall that must not raise an event.
        hold(10, 4'b0001, 4'b1111);
        cycle(4'b0001, MODES, 4'b1111, 4'b0001);
        hold(10, 4'b0000, 4'b1111);

        // ch1 both edges: short glitch, then a long pulse giving overflow.
        hold(3, 4'b0010, 4'b1111);
        hold(10, 4'b0000, 4'b1111);
        hold(10, 4'b0010, 4'b1111);
        hold(12, 4'b0000, 4'b1111);
        cycle(4'b0000, MODES, 4'b1111, 4'b1111);

        // ch2 level mode: clear ineffective while high, effective after the fall.
        hold(10, 4'b0100, 4'b1111);
        cycle(4'b0100, MODES, 4'b1111, 4'b0100);
        hold(3, 4'b0100, 4'b1111);
        hold(8, 4'b0000, 4'b1111);
        cycle(4'b0000, MODES, 4'b1111, 4'b0100);
        hold(2, 4'b0000, 4'b1111);

        // ch3 enable masking and re-enable.
        hold(10, 4'b1000, 4'b0111);
        hold(10, 4'b0000, 4'b0111);
        hold(10, 4'b1000, 4'b1111);
        hold(3, 4'b1000, 4'b0111);
        hold(3, 4'b1000, 4'b1111);
        hold(10, 4'b0000, 4'b1111);
        cycle(4'b0000, MODES, 4'b1111, 4'b1111);
        hold(2, 4'b0000, 4'b1111);

        // All channels rise together with clear held through the event edge.
        repeat (6) cycle(4'b1111, MODES, 4'b1111, 4'b1111);
        hold(4, 4'b1111, 4'b1111);

        cur_b = 4'b1111;
        cur_e = 4'b1111;
        cur_m = MODES;
        for (int n = 0; n < 1500; n++) begin
            cur_c = '0;
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 9) == 0) cur_b[k] = ~cur_b[k];
                if ($urandom_range(0, 5) == 0) cur_c[k] = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) cur_e[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) cur_m = 8'($urandom);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            cycle(cur_b, cur_m, cur_e, cur_c);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
